// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: synchronises and debounces eight buttons plus a mode button,
// forms single-cycle press pulses and drives the LED bank in DIRECT, TOGGLE
// or RUN (running light) mode.
// Build option: define BTN_LED_CTRL_DEBOUNCE_EN to enable the per-input
// debounce counters; otherwise the synchroniser output is used unfiltered.
module btn_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_PERIOD      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btns,
    input  logic       mode_btn,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic [7:0] press
);

    localparam int NIN = 9;                  // 8 buttons + mode button (bit 8)
    localparam int TW  = $clog2(RUN_PERIOD);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_RUN    = 2'd2
    } mode_t;

    logic [NIN-1:0] raw;
    logic [NIN-1:0] sync1_q;
    logic [NIN-1:0] sync2_q;
    logic [NIN-1:0] db;
    logic [NIN-1:0] db_dly_q;
    logic           mpress;

    mode_t          mode_q;
    logic [7:0]     leds_q;
    logic [TW-1:0]  tick_q;

    assign raw = {mode_btn, btns};

    // Two-flop synchroniser for all raw pin inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_LED_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_db
            logic [CW-1:0] cnt_q;
            logic          db_bit_q;

            // Stable value only follows the input after it has differed
            // for DEBOUNCE_CYCLES consecutive samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q    <= '0;
                    db_bit_q <= 1'b0;
                end else if (sync2_q[gi] == db_bit_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_bit_q <= sync2_q[gi];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign db[gi] = db_bit_q;
        end
    endgenerate
`else
    // Without the filter the synchronised input is the stable value, so
    // glitches reach the LEDs and DEBOUNCE_CYCLES has no effect.
    logic [31:0] unused_debounce_cycles;
    assign unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign db = sync2_q;
`endif

    // One-cycle delayed copy of the stable values for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_dly_q <= '0;
        end else begin
            db_dly_q <= db;
        end
    end

    assign press  = db[7:0] & ~db_dly_q[7:0];
    assign mpress = db[8] & ~db_dly_q[8];

    // Mode FSM with LED and running-light tick registers; a mode change
    // takes priority and discards button presses from the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_DIRECT;
            leds_q <= '0;
            tick_q <= '0;
        end else if (mpress) begin
            case (mode_q)
                MODE_DIRECT: begin
                    mode_q <= MODE_TOGGLE;
                    leds_q <= 8'h00;
                end
                MODE_TOGGLE: begin
                    mode_q <= MODE_RUN;
                    leds_q <= 8'h01;
                    tick_q <= '0;
                end
                default: begin
                    mode_q <= MODE_DIRECT;
                    leds_q <= db[7:0];
                end
            endcase
        end else begin
            case (mode_q)
                MODE_DIRECT: begin
                    leds_q <= db[7:0];
                end
                MODE_TOGGLE: begin
                    leds_q <= leds_q ^ press;
                end
                MODE_RUN: begin
                    if (press != 8'h00) begin
                        // Isolate the lowest set press bit as the new light.
                        leds_q <= press & (~press + 8'd1);
                        tick_q <= '0;
                    end else if (tick_q == TW'(RUN_PERIOD - 1)) begin
                        leds_q <= {leds_q[6:0], leds_q[7]};
                        tick_q <= '0;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: recover to a known state.
                    mode_q <= MODE_DIRECT;
                    leds_q <= 8'h00;
                end
            endcase
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed testbench for btn_led_ctrl (DEBOUNCE_CYCLES=4, RUN_PERIOD=8).
// Expected latencies follow the BTN_LED_CTRL_DEBOUNCE_EN build option.
module tb_btn_led_ctrl;

`ifdef BTN_LED_CTRL_DEBOUNCE_EN
    localparam int LAT   = 4 + 3;   // pin to LED latency in edges
    localparam bit DB_EN = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] btns;
    logic       mode_btn;
    logic [7:0] leds;
    logic [1:0] mode;
    logic [7:0] press;

    int         chk_cnt;
    int         err_cnt;
    int         press_cnt;
    logic [7:0] press_or;
    int         led1_cnt;

    btn_led_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_PERIOD     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btns    (btns),
        .mode_btn(mode_btn),
        .leds    (leds),
        .mode    (mode),
        .press   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    task automatic clr_mon();
        press_cnt = 0;
        press_or  = 8'h00;
        led1_cnt  = 0;
    endtask

    // Drive inputs just after an edge, then advance n edges, observing #1 after each.
    task automatic hold(input logic [7:0] b, input logic m, input int n);
        btns     = b;
        mode_btn = m;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (press != 8'h00) begin
                press_cnt++;
                press_or = press_or | press;
            end
            if (leds[1]) led1_cnt++;
        end
    endtask

    initial begin
        chk_cnt  = 0;
        err_cnt  = 0;
        rst      = 1'b1;
        btns     = 8'h00;
        mode_btn = 1'b0;
        clr_mon();

        // Reset state
        hold(8'h00, 1'b0, 3);
        check_eq("rst_leds", 32'(leds), 32'h00);
        check_eq("rst_mode", 32'(mode), 32'h0);
        check_eq("rst_press", 32'(press), 32'h00);

        // DIRECT: btns=02 reaches leds exactly LAT edges after first sample
        rst = 1'b0;
        hold(8'h02, 1'b0, LAT - 1);
        check_eq("dir_leds_early", 32'(leds), 32'h00);
        check_eq("dir_press", 32'(press), 32'h02);
        hold(8'h02, 1'b0, 1);
        check_eq("dir_leds", 32'(leds), 32'h02);
        check_eq("dir_press_end", 32'(press), 32'h00);
        check_eq("dir_mode", 32'(mode), 32'h0);
        hold(8'h02, 1'b0, 10 - LAT);
        hold(8'h00, 1'b0, LAT + 2);
        check_eq("dir_release", 32'(leds), 32'h00);

        // Glitch: btns[1] high for 3 cycles
        clr_mon();
        hold(8'h02, 1'b0, 3);
        hold(8'h00, 1'b0, 10);
        check_eq("glitch_led_cycles", 32'(led1_cnt), DB_EN ? 32'd0 : 32'd3);
        check_eq("glitch_press_cnt", 32'(press_cnt), DB_EN ? 32'd0 : 32'd1);

        // TOGGLE entry
        hold(8'h00, 1'b1, LAT + 2);
        check_eq("tog_mode", 32'(mode), 32'h1);
        check_eq("tog_leds", 32'(leds), 32'h00);
        hold(8'h00, 1'b0, LAT + 2);
        clr_mon();
        hold(8'h08, 1'b0, LAT + 2);
        check_eq("tog1_leds", 32'(leds), 32'h08);
        check_eq("tog1_pulses", 32'(press_cnt), 32'd1);
        check_eq("tog1_press", 32'(press_or), 32'h08);
        clr_mon();
        hold(8'h00, 1'b0, LAT + 2);
        check_eq("tog_rel_leds", 32'(leds), 32'h08);
        check_eq("tog_rel_pulses", 32'(press_cnt), 32'd0);
        clr_mon();
        hold(8'h08, 1'b0, LAT + 2);
        check_eq("tog2_leds", 32'(leds), 32'h00);
        check_eq("tog2_pulses", 32'(press_cnt), 32'd1);
        hold(8'h00, 1'b0, LAT + 2);

        // RUN entry and rotation
        hold(8'h00, 1'b1, LAT - 1);
        check_eq("run_mode_early", 32'(mode), 32'h1);
        hold(8'h00, 1'b1, 1);
        check_eq("run_mode", 32'(mode), 32'h2);
        check_eq("run_entry", 32'(leds), 32'h01);
        hold(8'h00, 1'b0, 7);
        check_eq("run_before_shift", 32'(leds), 32'h01);
        hold(8'h00, 1'b0, 1);
        check_eq("run_shift1", 32'(leds), 32'h02);
        hold(8'h00, 1'b0, 55);
        check_eq("run_bit7", 32'(leds), 32'h80);
        hold(8'h00, 1'b0, 1);
        check_eq("run_wrap", 32'(leds), 32'h01);

        // RUN reload from btns=60
        clr_mon();
        hold(8'h60, 1'b0, LAT - 1);
        check_eq("reload_press", 32'(press), 32'h60);
        hold(8'h60, 1'b0, 1);
        check_eq("reload_leds", 32'(leds), 32'h20);
        clr_mon();
        hold(8'h60, 1'b0, 7);
        check_eq("reload_hold", 32'(leds), 32'h20);
        hold(8'h60, 1'b0, 1);
        check_eq("reload_shift", 32'(leds), 32'h40);
        check_eq("reload_no_repress", 32'(press_cnt), 32'd0);
        hold(8'h00, 1'b0, LAT + 2);

        // Simultaneous mode and btns[0] press: mode change wins
        hold(8'h01, 1'b1, LAT - 1);
        check_eq("simul_press", 32'(press), 32'h01);
        hold(8'h01, 1'b1, 1);
        check_eq("simul_mode", 32'(mode), 32'h0);
        check_eq("simul_leds", 32'(leds), 32'h01);
        hold(8'h00, 1'b0, LAT + 2);
        check_eq("simul_rel_mode", 32'(mode), 32'h0);
        check_eq("simul_rel_leds", 32'(leds), 32'h00);

        // Back to RUN, then reset mid-operation with a press pulse live
        hold(8'h00, 1'b1, LAT + 2);
        hold(8'h00, 1'b0, LAT + 2);
        hold(8'h00, 1'b1, LAT + 2);
        hold(8'h00, 1'b0, LAT + 2);
        check_eq("rerun_mode", 32'(mode), 32'h2);
        hold(8'h04, 1'b0, LAT - 1);
        check_eq("pre_rst_press", 32'(press), 32'h04);
        rst = 1'b1;
        hold(8'h00, 1'b0, 1);
        check_eq("mid_rst_leds", 32'(leds), 32'h00);
        check_eq("mid_rst_mode", 32'(mode), 32'h0);
        check_eq("mid_rst_press", 32'(press), 32'h00);
        rst = 1'b0;
        clr_mon();
        hold(8'h00, 1'b0, 12);
        check_eq("post_rst_pulses", 32'(press_cnt), 32'd0);
        check_eq("post_rst_leds", 32'(leds), 32'h00);
        check_eq("post_rst_mode", 32'(mode), 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
